// File: rtl/rotary_cursor_ctrl.sv
// Rotary encoder front end: sync + debounce A/B/press, quadrature step decode,
// 1..9 wrap cursor and select strobe. Optional macro SKIP_OCCUPIED_EN skips claimed squares.

module rcc_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic filt,
  output logic rise
);
  logic s1_q, s1_d, s2_q, s2_d, filt_q, filt_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    filt_d = filt_q;
    prev_d = filt_q;
    cnt_d  = '0;
    // Accept the new level only on the DEBOUNCE_CYCLES-th consecutive disagreement.
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 16'd1)) filt_d = s2_q;
      else                                          cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
  assign rise = filt_q & ~prev_q;
endmodule

module rotary_cursor_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rot_a,
  input  logic       rot_b,
  input  logic       rot_press,
  input  logic [8:0] occupied,
  output logic [7:0] square_num,
  output logic       enter_pulse,
  output logic       step_cw,
  output logic       step_ccw
);
  localparam int NIN = 3;  // 0 = A, 1 = B, 2 = press

  logic [NIN-1:0] raw, filt, rise;
  assign raw = {rot_press, rot_b, rot_a};

  for (genvar i = 0; i < NIN; i++) begin : g_in
    rcc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk  (clk),
      .clr  (clr),
      .raw  (raw[i]),
      .filt (filt[i]),
      .rise (rise[i])
    );
  end

  logic unused_dbg;
  assign unused_dbg = ^{filt[0], filt[2], rise[1]};

  logic [3:0] square_q, square_d;
  logic       enter_q, enter_d, step_cw_q, step_cw_d, step_ccw_q, step_ccw_d;
  logic       dir_cw, step_ok, sel_ok;
  logic [3:0] step_tgt;

  function automatic logic [3:0] wrap_step(input logic [3:0] n, input logic cw);
    if (cw) return (n >= 4'd9) ? 4'd1 : n + 4'd1;
    else    return (n <= 4'd1) ? 4'd9 : n - 4'd1;
  endfunction

  assign dir_cw = ~filt[1];

`ifdef SKIP_OCCUPIED_EN
  logic [15:0] occ_ext;
  logic [3:0]  cand;
  assign occ_ext = {7'd0, occupied};

  always_comb begin
    step_ok  = 1'b0;
    step_tgt = square_q;
    cand     = square_q;
    // Walk up to a full lap; the first free square wins.
    for (int i = 0; i < 9; i++) begin
      cand = wrap_step(cand, dir_cw);
      if (!step_ok && !occ_ext[cand - 4'd1]) begin
        step_ok  = 1'b1;
        step_tgt = cand;
      end
    end
    sel_ok = (square_q != 4'd0) && !occ_ext[square_q - 4'd1];
  end
`else
  logic unused_occ;
  assign unused_occ = ^occupied;

  always_comb begin
    step_ok  = 1'b1;
    step_tgt = wrap_step(square_q, dir_cw);
    sel_ok   = (square_q != 4'd0);
  end
`endif

  always_comb begin
    square_d   = square_q;
    enter_d    = 1'b0;
    step_cw_d  = 1'b0;
    step_ccw_d = 1'b0;
    // A press in the same cycle as an A rise swallows the step.
    if (rise[2]) begin
      enter_d = sel_ok;
    end else if (rise[0] && step_ok) begin
      square_d   = step_tgt;
      step_cw_d  = dir_cw;
      step_ccw_d = ~dir_cw;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      square_q   <= 4'd0;
      enter_q    <= 1'b0;
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
    end else begin
      square_q   <= square_d;
      enter_q    <= enter_d;
      step_cw_q  <= step_cw_d;
      step_ccw_q <= step_ccw_d;
    end
  end

  assign square_num  = {4'd0, square_q};
  assign enter_pulse = enter_q;
  assign step_cw     = step_cw_q;
  assign step_ccw    = step_ccw_q;
endmodule

// File: tb/tb_rotary_cursor_ctrl.sv
// Directed + randomized bench for rotary_cursor_ctrl against a window-based reference model.
module tb_rotary_cursor_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       rot_a, rot_b, rot_press;
  logic [8:0] occupied;
  logic [7:0] square_num;
  logic       enter_pulse, step_cw, step_ccw;

  rotary_cursor_ctrl #(.DEBOUNCE_CYCLES(16'(D)), .CNT_W(16)) dut (
    .clk         (clk),
    .clr         (clr),
    .rot_a       (rot_a),
    .rot_b       (rot_b),
    .rot_press   (rot_press),
    .occupied    (occupied),
    .square_num  (square_num),
    .enter_pulse (enter_pulse),
    .step_cw     (step_cw),
    .step_ccw    (step_ccw)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int n_enter, n_cw, n_ccw;

  // Reference model: raw sample history, filtered levels, cursor.
  logic [2:0] hist [0:15];
  logic [2:0] mfilt, mprev;
  int         msq;
  logic       menter, mcw, mccw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 16; j++) hist[j] = 3'b000;
    mfilt = 3'b000; mprev = 3'b000;
    msq = 0; menter = 1'b0; mcw = 1'b0; mccw = 1'b0;
  endtask

  function automatic int cw_of(input int n);
    return (n % 9) + 1;
  endfunction
  function automatic int ccw_of(input int n);
    return (n <= 1) ? 9 : n - 1;
  endfunction

  // One clock edge of the model; r is the raw level sampled at this edge.
  task automatic model_edge(input logic [2:0] r);
    logic ra, rp, cw, found, all_dis;
    int   tgt, c;
    ra = mfilt[0] & ~mprev[0];
    rp = mfilt[2] & ~mprev[2];
    menter = 1'b0; mcw = 1'b0; mccw = 1'b0;
    if (rp) begin
      if (msq != 0) begin
`ifdef SKIP_OCCUPIED_EN
        menter = !occupied[msq-1];
`else
        menter = 1'b1;
`endif
      end
    end else if (ra) begin
      cw = !mfilt[1];
`ifdef SKIP_OCCUPIED_EN
      found = 1'b0; tgt = msq; c = msq;
      for (int k = 0; k < 9; k++) begin
        c = cw ? cw_of(c) : ccw_of(c);
        if (!found && !occupied[c-1]) begin found = 1'b1; tgt = c; end
      end
`else
      found = 1'b1; c = 0;
      tgt = cw ? cw_of(msq) : ccw_of(msq);
`endif
      if (found) begin
        msq = tgt; mcw = cw; mccw = !cw;
      end
    end
    mprev = mfilt;
    // Filter flips when the D synchronised samples seen by this edge all disagree.
    for (int i = 0; i < 3; i++) begin
      all_dis = 1'b1;
      for (int j = 1; j <= D; j++) if (hist[j][i] == mfilt[i]) all_dis = 1'b0;
      if (all_dis) mfilt[i] = ~mfilt[i];
    end
    for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = r;
  endtask

  task automatic tick(input logic a, input logic b, input logic p);
    rot_a = a; rot_b = b; rot_press = p;
    @(posedge clk);
    model_edge({p, b, a});
    @(negedge clk);
    chk("square_num", square_num, 32'(msq));
    chk("enter_pulse", enter_pulse, menter);
    chk("step_cw", step_cw, mcw);
    chk("step_ccw", step_ccw, mccw);
    n_enter += int'(enter_pulse);
    n_cw    += int'(step_cw);
    n_ccw   += int'(step_ccw);
  endtask

  task automatic hold(input logic a, input logic b, input logic p, input int n);
    repeat (n) tick(a, b, p);
  endtask

  task automatic clear_counts();
    n_enter = 0; n_cw = 0; n_ccw = 0;
  endtask

  task automatic detent(input logic cw);
    hold(1'b0, !cw, 1'b0, 6);
    hold(1'b1, !cw, 1'b0, 8);
    hold(1'b0, !cw, 1'b0, 8);
    hold(1'b0, 1'b0, 1'b0, 6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int ca [3], va [3];
    clr = 1'b1; rot_a = 1'b0; rot_b = 1'b0; rot_press = 1'b0; occupied = 9'd0;
    model_reset();
    clear_counts();
    repeat (2) @(negedge clk);
    chk("rst_square", square_num, 0);
    chk("rst_enter", enter_pulse, 0);
    chk("rst_cw", step_cw, 0);
    chk("rst_ccw", step_ccw, 0);
    clr = 1'b0;

    // Press with no cursor is swallowed.
    hold(1'b0, 1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 1'b0, 8);
    chk("press_at_0", n_enter, 0);

    // First CW step: output moves exactly D+2 edges after first sample.
    repeat (D + 2) tick(1'b1, 1'b0, 1'b0);
    chk("lat_before", square_num, 0);
    tick(1'b1, 1'b0, 1'b0);
    chk("lat_square", square_num, 1);
    chk("lat_cw", step_cw, 1);
    tick(1'b1, 1'b0, 1'b0);
    chk("cw_one_cycle", step_cw, 0);
    hold(1'b0, 1'b0, 1'b0, 8);

    repeat (8) detent(1'b1);
    chk("cw_to_9", square_num, 9);
    detent(1'b1);
    chk("wrap_9_to_1", square_num, 1);
    detent(1'b0);
    chk("wrap_1_to_9", square_num, 9);

    do_reset();
    detent(1'b0);
    chk("ccw_from_0", square_num, 9);

    // Short glitch on A must not move anything.
    clear_counts();
    hold(1'b1, 1'b0, 1'b0, 3);
    hold(1'b0, 1'b0, 1'b0, 10);
    chk("glitch_square", square_num, 9);
    chk("glitch_strobes", n_cw + n_ccw, 0);

    repeat (5) detent(1'b1);
    chk("nav_to_5", square_num, 5);
    clear_counts();
    hold(1'b0, 1'b0, 1'b1, 100);
    hold(1'b0, 1'b0, 1'b0, 10);
    chk("held_press_count", n_enter, 1);
    chk("held_press_square", square_num, 5);

    repeat (2) detent(1'b0);
    chk("nav_to_3", square_num, 3);
    clear_counts();
    hold(1'b1, 1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 1'b0, 10);
    chk("coll_enter", n_enter, 1);
    chk("coll_cw", n_cw, 0);
    chk("coll_square", square_num, 3);

`ifdef SKIP_OCCUPIED_EN
    do_reset();
    detent(1'b1);
    chk("skip_start", square_num, 1);
    occupied = 9'b000001110;
    detent(1'b1);
    chk("skip_to_5", square_num, 5);
    occupied = 9'h1FF;
    clear_counts();
    detent(1'b1);
    chk("full_hold", square_num, 5);
    chk("full_no_strobe", n_cw + n_ccw, 0);
    occupied = 9'd0;
`endif

    // Random phase: each input holds a random level for a random span.
    for (int i = 0; i < 3; i++) begin ca[i] = 0; va[i] = 0; end
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (ca[i] == 0) begin
          va[i] = int'($urandom_range(0, 1));
          ca[i] = int'($urandom_range(1, 10));
        end
        ca[i]--;
      end
      if (t % 60 == 0) occupied = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
      tick(va[0][0], va[1][0], va[2][0]);
    end
    occupied = 9'd0;
    hold(1'b0, 1'b0, 1'b0, 10);

    // Reset mid-debounce clears outputs without waiting for an edge.
    detent(1'b1);
    hold(1'b1, 1'b0, 1'b0, 2);
    #2 clr = 1'b1;
    #1;
    chk("async_square", square_num, 0);
    chk("async_enter", enter_pulse, 0);
    chk("async_cw", step_cw, 0);
    chk("async_ccw", step_ccw, 0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    hold(1'b0, 1'b0, 1'b0, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rotary_cursor_ctrl.md
Name: rotary_cursor_ctrl

Overview:
- Front-end input block for the tic-tac-toe game. It is the producer side of the cursor/select interface that the board renderer and square-status logic consume.
- Decodes the board's rotary encoder (quadrature A/B plus push button) into a 1..9 cursor (`square_num`) and a single-cycle select pulse (`enter_pulse`, which drives the `ROTCTR_debounce` net).
- Contains the synchronisers, debouncers, quadrature step detector, cursor wrap counter and press-edge detector.

Parameters:
- `DEBOUNCE_CYCLES`, 16'd50000, number of consecutive clk cycles a synchronised input must disagree with its filtered value before the filtered value changes (1 ms at 50 MHz).
- `CNT_W`, 16, width of each debounce counter; must hold `DEBOUNCE_CYCLES`.

Ports:
- `clk`  in  1  system clock (50 MHz)
- `clr`  in  1  reset, asynchronous, active-high
- `rot_a`  in  1  raw rotary channel A, asynchronous to clk
- `rot_b`  in  1  raw rotary channel B, asynchronous to clk
- `rot_press`  in  1  raw rotary push button, active-high, asynchronous
- `occupied`  in  9  bit i-1 set = square i already claimed; used only with `SKIP_OCCUPIED_EN`
- `square_num`  out  8  cursor square: 0 = none, 1..9 = square; values 10..255 never driven
- `enter_pulse`  out  1  one-cycle select strobe (the `ROTCTR_debounce` net)
- `step_cw`  out  1  one-cycle strobe, clockwise step accepted (debug)
- `step_ccw`  out  1  one-cycle strobe, counter-clockwise step accepted (debug)

Behaviour:
- Reset: clr asserted → all state clears asynchronously, whether or not an operation is in progress:
  - `square_num` = 0; `enter_pulse`, `step_cw`, `step_ccw` = 0.
  - Sync flops, filtered values and debounce counters = 0.
  - No outputs pulse on the first cycles after reset release; edge detectors also reset to 0.
- Synchronisation: each raw input passes through a 2-flop synchroniser (`s1` → `s2`).
- Debounce, per input independently:
  - Counter increments on every edge where `s2` != `filt`; clears to 0 on any edge where `s2` == `filt`.
  - `filt` <= `s2`, and the counter clears, on the `DEBOUNCE_CYCLES`-th consecutive disagreeing edge.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles produces no `filt` change.
- Edge detect: `filt_d` is a registered copy of `filt`.
  - `rise_a` = `filt_a` & ~`filt_d_a`.
  - `rise_p` = `filt_p` & ~`filt_d_p`.
- Step decode: on `rise_a`, read `filt_b` in the same cycle.
  - `filt_b` = 0 → clockwise step (+1).
  - `filt_b` = 1 → counter-clockwise step (−1).
  - Falling edges of A and all edges of B generate no step.
- Cursor update, registered:
  - CW: 0→1, n→n+1 for n<9, 9→1.
  - CCW: 0→9, n→n−1 for n>1, 1→9.
  - Cursor never returns to 0 except by reset.
- Select:
  - `rise_p` with `square_num` != 0 → `enter_pulse` = 1 for exactly one cycle; `square_num` holds that cycle.
  - `rise_p` with `square_num` == 0 → suppressed, no pulse.
  - Button release generates nothing; holding the button generates one pulse only.
- Simultaneous `rise_a` and `rise_p` in the same cycle: press wins, the step is discarded, and neither `step_cw` nor `step_ccw` pulses.
- Latency: an input level first sampled into `s1` at edge k and held stable changes outputs at edge k+`DEBOUNCE_CYCLES`+2, exactly.
- `step_cw`/`step_ccw` assert in the same cycle `square_num` changes.
- `DEBOUNCE_CYCLES` = 0 is illegal; the debouncer is defined only for values ≥ 1.

Optional Feature:
- Macro: `SKIP_OCCUPIED_EN`.
- Defined:
  - A step advances past squares whose `occupied` bit is set, searching at most 9 positions in the step direction with wrap.
  - The move completes in the same single update cycle.
  - If every square is occupied, `square_num` holds and no step strobe fires.
  - `enter_pulse` is suppressed when the current square is occupied.
- Undefined: `occupied` is ignored (no logic depends on it); behaviour is exactly as above.

Test Plan:
- Reset with `DEBOUNCE_CYCLES`=4, then A rises with B=0, held → `square_num` 0→1 exactly 6 edges after A is first sampled; `step_cw` high 1 cycle.
- From `square_num`=9, one CW detent → 1. From 1, one CCW detent (A rises, B=1) → 9. From reset, the first CCW detent → 9.
- A glitch high for 3 cycles, then low → no `filt` change, `square_num` unchanged, no strobes.
- Press at `square_num`=0 → no `enter_pulse`. Press at 5, held 100 cycles → exactly one `enter_pulse`, `square_num` stays 5.
- A rise (B=0) and press edges aligned to the same filtered cycle at `square_num`=3 → `enter_pulse`=1, `square_num` stays 3, `step_cw`=0.
- With `SKIP_OCCUPIED_EN`, `occupied`=9'b000001110, cursor at 1, CW → 5; with `occupied`=9'h1FF, CW → holds, no strobe. Assert clr mid-debounce → all outputs 0 immediately.
